resync_unit: RTL and testbench
==============================

Name: resync_unit

Overview:
- Clock-domain entry block for the ADC front end. It brings an external active-low reset request and asynchronous data lines into the `clk` domain.
- It produces a stretched, synchronized active-low reset (`rstn_o`) for downstream logic.
- It produces metastability-hardened data (`data_o`) that is held cleared while `rstn_o` is low.
- It produces one-cycle rise/fall pulses on the synchronized data.

Parameters:
- STAGES, 2, number of synchronizer flops per chain; legal values are 2 or more.
- WIDTH, 1, data bus width in bits.
- MIN_LOW, 4, extra `clk` cycles that `rstn_o` stays low after the synchronized request goes high; 0 is legal.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset (polarity and synchronicity fixed).
- rstn_i  in  1  raw active-low reset request, asynchronous to clk.
- data_i  in  WIDTH  raw data, asynchronous to clk; each bit is independent.
- rstn_o  out  1  synchronized, stretched active-low reset, registered.
- data_o  out  WIDTH  synchronized data, last flop of the data chain.
- rise_o  out  WIDTH  per-bit one-cycle pulse on a 0->1 transition of `data_o`.
- fall_o  out  WIDTH  per-bit one-cycle pulse on a 1->0 transition of `data_o`.

Behaviour:
- Reset (`rst`=1 at an edge):
  - reset chain r[0..STAGES-1]=0, counter cnt=MIN_LOW, `rstn_o`=0.
  - data chain d[0..STAGES-1]=0, edge register dq=0.
  - Consequently `data_o`, `rise_o` and `fall_o` are all 0.
  - `rst` overrides everything, including mid-operation.
- Reset chain, each edge:
  - r[0]<=`rstn_i`; r[k]<=r[k-1].
- Stretch logic uses the pre-edge value of r[STAGES-1]:
  - If it is 0: cnt<=MIN_LOW and `rstn_o`<=0.
  - Else if cnt!=0: cnt<=cnt-1 and `rstn_o`<=0.
  - Else: `rstn_o`<=1.
  - cnt width is $clog2(MIN_LOW+1), minimum 1 bit. It never underflows.
- Assertion latency: `rstn_i` first sampled low at edge n gives `rstn_o`=0 after edge n+STAGES.
- Release latency: `rstn_i` first sampled high at edge m, and held, gives `rstn_o`=1 after edge m+STAGES+MIN_LOW.
  - Edge 0 is the first edge with `rst`=0 when `rstn_i` is already high.
  - Defaults give `rstn_o` rising after edge 6.
- Any sampled low pulse, even one cycle long, restarts the full stretch.
- A low re-entering during countdown reloads cnt.
- Data chain:
  - d[0]<=`data_i`; d[k]<=d[k-1]; `data_o`=d[STAGES-1].
  - Latency is STAGES-1 edges after first sampling (defaults: value sampled at edge n appears after edge n+1).
  - While `rstn_o`=0 (registered value, pre-edge) the whole data chain and dq are cleared to 0 every edge.
- Edge detect:
  - dq<=`data_o` each edge.
  - `rise_o`=`data_o` & ~dq, combinational; `fall_o`=~`data_o` & dq, combinational.
  - Both are forced to 0 while `rstn_o`=0.
  - Each pulse lasts exactly one cycle per transition.
  - A bit held high across `rstn_o` release produces one `rise_o` pulse once the chain refills.
- No combinational path from any input to any output.

Decomposition:
- Package resync_pkg:
  - default constants RESYNC_STAGES=2, RESYNC_MIN_LOW=4.
  - function for the cnt width.
- One sub-module, sync_chain:
  - parameterized STAGES and WIDTH.
  - synchronous clear input.
  - instantiated twice: for the reset chain (WIDTH=1) and for the data chain.
- Stretch counter and edge detect live in resync_unit.

Test Plan:
- `rst`=1 for 3 cycles, `rstn_i`=1, `data_i`=1 -> during reset `rstn_o`=0, `data_o`=0, `rise_o`=`fall_o`=0. After release `rstn_o` rises after edge 6. `data_o`=1 two edges later, with one `rise_o` pulse.
- After `rstn_o`=1, drive `rstn_i`=0 for one cycle at edge n -> `rstn_o`=0 after edge n+2, then 1 again after edge n+1+2+4 = n+7. `data_o` is cleared meanwhile.
- Drop `rstn_i` low again during the countdown -> cnt reloads. `rstn_o` rises 6 edges after the final high is sampled.
- With `rstn_o`=1, toggle `data_i` bit 0 high at edge k and low at edge k+5 -> `data_o` high after edge k+1 and low after edge k+6. `rise_o`=1 for exactly one cycle after edge k+1, `fall_o`=1 for exactly one cycle after edge k+6.
- Assert `rst` mid-operation with `data_o`=1 -> next edge all outputs 0, cnt=MIN_LOW.
- Parameter sweep STAGES=3, MIN_LOW=0, WIDTH=8: `data_i`=8'hA5 -> `data_o`=8'hA5 two edges later, with `rise_o`=8'hA5 for one cycle. `rstn_o` release latency is 3 edges.

Source files
------------

// File: rtl/resync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : resync_pkg
// Description : Shared defaults and helpers for the resync_unit block.
// Revision    : 1.0 - initial release
// ============================================================================
package resync_pkg;

  // Default synchronizer depth and minimum reset-low stretch.
  localparam int RESYNC_STAGES  = 2;
  localparam int RESYNC_MIN_LOW = 4;

  // The stretch counter must hold MIN_LOW. It is kept at least one bit wide
  // so that MIN_LOW = 0 still yields a legal vector.
  function automatic int cnt_width(input int min_low);
    int w;
    w = $clog2(min_low + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : resync_pkg
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
// Module      : sync_chain
// Description : Multi-flop synchronizer shift chain with synchronous reset
//               and synchronous clear. q is the last flop of the chain.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_chain #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  // Shift the raw input through the chain; reset and clear both empty it.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int k = 0; k < STAGES; k++) begin
        stage[k] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int k = 1; k < STAGES; k++) begin
        stage[k] <= stage[k-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule : sync_chain
`default_nettype wire

// File: rtl/resync_unit.sv
`default_nettype none
// ============================================================================
// Module      : resync_unit
// Description : Clock-domain entry for the ADC front end. Synchronizes and
//               stretches an active-low reset request, synchronizes data
//               lines (held cleared during reset) and flags per-bit edges.
// Revision    : 1.0 - initial release
// ============================================================================
module resync_unit
  import resync_pkg::*;
#(
  parameter int STAGES  = RESYNC_STAGES,
  parameter int WIDTH   = 1,
  parameter int MIN_LOW = RESYNC_MIN_LOW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             rstn_o,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  localparam int            CW       = cnt_width(MIN_LOW);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MIN_LOW);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic             rst_req_sync;  // synchronized reset request, active low
  logic [CW-1:0]    cnt;           // remaining stretch cycles
  logic [WIDTH-1:0] dq;            // previous data_o for edge detection
  logic             data_clr;

  // Reset request chain; only the block reset empties it.
  sync_chain #(
    .STAGES (STAGES),
    .WIDTH  (1)
  ) u_rst_chain (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .d   (rstn_i),
    .q   (rst_req_sync)
  );

  // Data lines are flushed for every cycle the stretched reset is asserted,
  // so downstream never sees stale data on release.
  assign data_clr = ~rstn_o;

  sync_chain #(
    .STAGES (STAGES),
    .WIDTH  (WIDTH)
  ) u_data_chain (
    .clk (clk),
    .rst (rst),
    .clr (data_clr),
    .d   (data_i),
    .q   (data_o)
  );

  // Stretch the synchronized request: any sampled low reloads the counter,
  // and rstn_o releases only once the counter has drained to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= CNT_LOAD;
      rstn_o <= 1'b0;
    end else if (!rst_req_sync) begin
      cnt    <= CNT_LOAD;
      rstn_o <= 1'b0;
    end else if (cnt != '0) begin
      cnt    <= cnt - CNT_ONE;
      rstn_o <= 1'b0;
    end else begin
      rstn_o <= 1'b1;
    end
  end

  // Remember the previous synchronized data for edge detection.
  always_ff @(posedge clk) begin
    if (rst || !rstn_o) begin
      dq <= '0;
    end else begin
      dq <= data_o;
    end
  end

  // Edge pulses derive only from registered state, so no input reaches
  // an output combinationally.
  assign rise_o = data_o & ~dq & {WIDTH{rstn_o}};
  assign fall_o = ~data_o & dq & {WIDTH{rstn_o}};

endmodule : resync_unit
`default_nettype wire

// File: tb/tb_resync_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_resync_unit
// Description : Directed self-checking bench for resync_unit: default
//               configuration plus a STAGES=3 / MIN_LOW=0 / WIDTH=8 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_resync_unit;

  logic       clk;
  logic       rst;
  logic       rstn_i;
  logic [0:0] data_i;
  logic       rstn_o;
  logic [0:0] data_o;
  logic [0:0] rise_o;
  logic [0:0] fall_o;

  logic       rst2;
  logic       rstn2_i;
  logic [7:0] data2_i;
  logic       rstn2_o;
  logic [7:0] data2_o;
  logic [7:0] rise2_o;
  logic [7:0] fall2_o;

  int checks = 0;
  int errors = 0;

  resync_unit dut (
    .clk    (clk),
    .rst    (rst),
    .rstn_i (rstn_i),
    .data_i (data_i),
    .rstn_o (rstn_o),
    .data_o (data_o),
    .rise_o (rise_o),
    .fall_o (fall_o)
  );

  resync_unit #(
    .STAGES  (3),
    .WIDTH   (8),
    .MIN_LOW (0)
  ) dut2 (
    .clk    (clk),
    .rst    (rst2),
    .rstn_i (rstn2_i),
    .data_i (data2_i),
    .rstn_o (rstn2_o),
    .data_o (data2_o),
    .rise_o (rise2_o),
    .fall_o (fall2_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rstn_i = 1'b1; data_i = 1'b1;
    rst2 = 1'b1; rstn2_i = 1'b1; data2_i = 8'hA5;

    // ---- Reset state and first release ----
    repeat (3) tick();
    check("rst_rstn", 32'(rstn_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_rise", 32'(rise_o), 32'd0);
    check("rst_fall", 32'(fall_o), 32'd0);
    rst = 1'b0;
    for (int e = 0; e < 6; e++) begin
      tick();                                   // edges 0..5
      check("rel_rstn_low", 32'(rstn_o), 32'd0);
    end
    tick();                                     // edge 6
    check("rel_rstn_high", 32'(rstn_o), 32'd1);
    check("rel_data_e6", 32'(data_o), 32'd0);
    tick();                                     // edge 7
    check("rel_data_e7", 32'(data_o), 32'd0);
    tick();                                     // edge 8
    check("rel_data_e8", 32'(data_o), 32'd1);
    check("rel_rise_e8", 32'(rise_o), 32'd1);
    tick();                                     // edge 9
    check("rel_rise_e9", 32'(rise_o), 32'd0);
    check("rel_data_e9", 32'(data_o), 32'd1);

    // ---- One-cycle low pulse on rstn_i ----
    rstn_i = 1'b0;
    tick();                                     // edge n
    rstn_i = 1'b1;
    check("pulse_n", 32'(rstn_o), 32'd1);
    tick();                                     // n+1
    check("pulse_n1", 32'(rstn_o), 32'd1);
    tick();                                     // n+2
    check("pulse_n2_rstn", 32'(rstn_o), 32'd0);
    check("pulse_n2_data", 32'(data_o), 32'd1);
    tick();                                     // n+3
    check("pulse_n3_data", 32'(data_o), 32'd0);
    check("pulse_n3_fall", 32'(fall_o), 32'd0);
    for (int e = 3; e < 7; e++) begin
      check("pulse_stretch", 32'(rstn_o), 32'd0);
      tick();                                   // n+4..n+7
    end
    check("pulse_n7_rstn", 32'(rstn_o), 32'd1);
    tick();                                     // n+8
    check("pulse_n8_data", 32'(data_o), 32'd0);
    tick();                                     // n+9
    check("pulse_n9_data", 32'(data_o), 32'd1);
    check("pulse_n9_rise", 32'(rise_o), 32'd1);

    // ---- Low re-entering during the countdown reloads the counter ----
    data_i = 1'b0;
    rstn_i = 1'b0;
    tick();                                     // a
    rstn_i = 1'b1;
    tick();                                     // a+1
    tick();                                     // a+2
    check("reload_a2", 32'(rstn_o), 32'd0);
    tick();                                     // a+3
    rstn_i = 1'b0;
    tick();                                     // a+4 low sampled
    rstn_i = 1'b1;
    tick();                                     // a+5 final high
    tick();                                     // a+6
    for (int e = 7; e < 11; e++) begin
      tick();                                   // a+7..a+10
      check("reload_low", 32'(rstn_o), 32'd0);
    end
    tick();                                     // a+11
    check("reload_a11", 32'(rstn_o), 32'd1);
    tick();
    tick();
    check("reload_data", 32'(data_o), 32'd0);
    check("reload_rise", 32'(rise_o), 32'd0);

    // ---- Data toggle with edge pulses ----
    data_i = 1'b1;
    tick();                                     // k
    check("tog_k_data", 32'(data_o), 32'd0);
    tick();                                     // k+1
    check("tog_k1_data", 32'(data_o), 32'd1);
    check("tog_k1_rise", 32'(rise_o), 32'd1);
    check("tog_k1_fall", 32'(fall_o), 32'd0);
    tick();                                     // k+2
    check("tog_k2_rise", 32'(rise_o), 32'd0);
    tick();                                     // k+3
    tick();                                     // k+4
    check("tog_k4_data", 32'(data_o), 32'd1);
    data_i = 1'b0;
    tick();                                     // k+5
    check("tog_k5_data", 32'(data_o), 32'd1);
    check("tog_k5_fall", 32'(fall_o), 32'd0);
    tick();                                     // k+6
    check("tog_k6_data", 32'(data_o), 32'd0);
    check("tog_k6_fall", 32'(fall_o), 32'd1);
    check("tog_k6_rise", 32'(rise_o), 32'd0);
    tick();                                     // k+7
    check("tog_k7_fall", 32'(fall_o), 32'd0);

    // ---- Mid-operation reset ----
    data_i = 1'b1;
    repeat (3) tick();
    check("mid_pre_data", 32'(data_o), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rstn", 32'(rstn_o), 32'd0);
    check("mid_data", 32'(data_o), 32'd0);
    check("mid_rise", 32'(rise_o), 32'd0);
    check("mid_fall", 32'(fall_o), 32'd0);
    check("mid_cnt", 32'(dut.cnt), 32'd4);
    rst = 1'b0;
    for (int e = 0; e < 6; e++) begin
      tick();                                   // edges 0..5
      check("mid_rel_low", 32'(rstn_o), 32'd0);
    end
    tick();                                     // edge 6
    check("mid_rel_high", 32'(rstn_o), 32'd1);

    // ---- STAGES=3, MIN_LOW=0, WIDTH=8 ----
    check("p_rst_rstn", 32'(rstn2_o), 32'd0);
    check("p_rst_data", 32'(data2_o), 32'd0);
    rst2 = 1'b0;
    for (int e = 0; e < 3; e++) begin
      tick();                                   // edges 0..2
      check("p_rstn_low", 32'(rstn2_o), 32'd0);
    end
    tick();                                     // edge 3
    check("p_rstn_high", 32'(rstn2_o), 32'd1);
    tick();                                     // edge 4
    tick();                                     // edge 5
    check("p_data_e5", 32'(data2_o), 32'd0);
    tick();                                     // edge 6
    check("p_data_e6", 32'(data2_o), 32'hA5);
    check("p_rise_e6", 32'(rise2_o), 32'hA5);
    check("p_fall_e6", 32'(fall2_o), 32'd0);
    tick();                                     // edge 7
    check("p_rise_e7", 32'(rise2_o), 32'd0);
    check("p_data_e7", 32'(data2_o), 32'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_resync_unit
`default_nettype wire
